ex_stage: RTL and testbench

//  Execute stage of the 5-stage RV32I pipeline, between the ID/EX and EX/MEM registers.
//  - Selects forwarded operands and runs the integer ALU.
//  - Resolves conditional branches and computes the branch/jump target.
//  - Holds the EX/MEM ALU-result register, which also serves as the EX->EX forwarding source.

---
 rtl/ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_ex_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32I pipeline.
// Forwards operands and runs the integer ALU. Resolves branches and jumps
// and computes the redirect target. Holds the EX/MEM ALU-result register,
// which is also the EX->EX forwarding source.
// Optional feature: define EX_MUL_EN to add the single-cycle RV32M multiply
// subset (MUL, MULH, MULHSU, MULHU) on the OP opcode with funct7 = 0000001.

`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`endif
`ifndef CTRL_BRANCH
`define CTRL_BRANCH 0
`endif

module ex_stage (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [31:0]                       id_ex_pc,
  input  logic [31:0]                       id_ex_instruction,
  input  logic [31:0]                       id_ex_rs1_data,
  input  logic [31:0]                       id_ex_rs2_data,
  input  logic [31:0]                       id_ex_immediate,
  input  logic [4:0]                        id_ex_rd_addr,
  input  logic [4:0]                        id_ex_rs1_addr,
  input  logic [4:0]                        id_ex_rs2_addr,
  input  logic [`CONTROL_SIGNALS_WIDTH-1:0] id_ex_control_signals,
  input  logic                              id_ex_valid,
  input  logic [1:0]                        forward_a,
  input  logic [1:0]                        forward_b,
  input  logic [31:0]                       mem_wb_alu_result,
  input  logic [31:0]                       mem_wb_mem_data,
  output logic [31:0]                       ex_mem_alu_result_fwd,
  output logic                              branch_taken,
  output logic [31:0]                       branch_target
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic [31:0] mul_result;
  logic        branch_cond;
  logic        is_jump;

  assign opcode = id_ex_instruction[6:0];
  assign funct3 = id_ex_instruction[14:12];
  assign funct7 = id_ex_instruction[31:25];

  // Operand forwarding: select rs1/rs2 from the register file or a later stage.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    fwd_rs1 = id_ex_rs1_data;
    fwd_rs2 = id_ex_rs2_data;
    case (forward_a)
      2'b01:   fwd_rs1 = mem_wb_alu_result;
      2'b10:   fwd_rs1 = ex_mem_alu_result_fwd;
      2'b11:   fwd_rs1 = mem_wb_mem_data;
      default: fwd_rs1 = id_ex_rs1_data;
    endcase
    case (forward_b)
      2'b01:   fwd_rs2 = mem_wb_alu_result;
      2'b10:   fwd_rs2 = ex_mem_alu_result_fwd;
      2'b11:   fwd_rs2 = mem_wb_mem_data;
      default: fwd_rs2 = id_ex_rs2_data;
    endcase
  end

  assign op_a  = fwd_rs1;
  assign op_b  = (opcode == OPC_OP || opcode == OPC_BRANCH) ? fwd_rs2 : id_ex_immediate;
  assign shamt = op_b[4:0];

`ifdef EX_MUL_EN
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [65:0] mul_prod;
  logic               mul_unused;

  // Multiplier: extend each operand to 33 bits so one signed multiply covers
  // the signed, signed-by-unsigned and unsigned forms.
  always_comb begin
    mul_a      = {op_a[31] & (funct3 == 3'b001 || funct3 == 3'b010), op_a};
    mul_b      = {op_b[31] & (funct3 == 3'b001), op_b};
    mul_prod   = mul_a * mul_b;
    mul_result = 32'd0;
    case (funct3)
      3'b000:                 mul_result = mul_prod[31:0];
      3'b001, 3'b010, 3'b011: mul_result = mul_prod[63:32];
      default:                mul_result = 32'd0;
    endcase
  end

  assign mul_unused = ^mul_prod[65:64];
`else
  assign mul_result = 32'd0;
`endif

  // Integer ALU decoded from opcode, funct3 and funct7.
  always_comb begin
    alu_result = 32'd0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        if (opcode == OPC_OP && funct7 == FUNCT7_MULDIV) begin
          alu_result = mul_result;
        end else begin
          case (funct3)
            3'b000: alu_result = (opcode == OPC_OP && funct7[5]) ? op_a - op_b : op_a + op_b;
            3'b001: alu_result = op_a << shamt;
            3'b010: alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            3'b011: alu_result = {31'd0, op_a < op_b};
            3'b100: alu_result = op_a ^ op_b;
            3'b101: alu_result = funct7[5] ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
            3'b110: alu_result = op_a | op_b;
            default: alu_result = op_a & op_b;
          endcase
        end
      end
      OPC_LOAD, OPC_STORE: alu_result = op_a + id_ex_immediate;
      OPC_LUI:             alu_result = id_ex_immediate;
      OPC_AUIPC:           alu_result = id_ex_pc + id_ex_immediate;
      OPC_JAL, OPC_JALR:   alu_result = id_ex_pc + 32'd4;
      default:             alu_result = 32'd0;
    endcase
  end

  // Branch condition on the forwarded register operands.
  always_comb begin
    branch_cond = 1'b0;
    case (funct3)
      3'b000:  branch_cond = (fwd_rs1 == fwd_rs2);
      3'b001:  branch_cond = (fwd_rs1 != fwd_rs2);
      3'b100:  branch_cond = ($signed(fwd_rs1) <  $signed(fwd_rs2));
      3'b101:  branch_cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      3'b110:  branch_cond = (fwd_rs1 <  fwd_rs2);
      3'b111:  branch_cond = (fwd_rs1 >= fwd_rs2);
      default: branch_cond = 1'b0;
    endcase
  end

  assign is_jump       = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign branch_taken  = !reset && id_ex_valid &&
                         ((branch_cond && id_ex_control_signals[`CTRL_BRANCH]) || is_jump);
  assign branch_target = (opcode == OPC_JALR) ? ((fwd_rs1 + id_ex_immediate) & ~32'h1)
                                              : id_ex_pc + id_ex_immediate;

  // EX/MEM result register: a bubble holds the previous value.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset here is synchronous and has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_alu_result_fwd <= 32'd0;
    end else if (id_ex_valid) begin
      ex_mem_alu_result_fwd <= alu_result;
    end
  end

  // Fields carried for later stages or debug that this stage does not use.
  logic unused;
  assign unused = ^{id_ex_rd_addr, id_ex_rs1_addr, id_ex_rs2_addr,
                    id_ex_instruction[24:15], id_ex_instruction[11:7],
                    id_ex_control_signals};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against a
// behavioural reference model written from the instruction-set rules.

`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`endif
`ifndef CTRL_BRANCH
`define CTRL_BRANCH 0
`endif

module tb_ex_stage;

  logic                              clk = 1'b0;
  logic                              reset;
  logic [31:0]                       id_ex_pc;
  logic [31:0]                       id_ex_instruction;
  logic [31:0]                       id_ex_rs1_data;
  logic [31:0]                       id_ex_rs2_data;
  logic [31:0]                       id_ex_immediate;
  logic [4:0]                        id_ex_rd_addr;
  logic [4:0]                        id_ex_rs1_addr;
  logic [4:0]                        id_ex_rs2_addr;
  logic [`CONTROL_SIGNALS_WIDTH-1:0] id_ex_control_signals;
  logic                              id_ex_valid;
  logic [1:0]                        forward_a;
  logic [1:0]                        forward_b;
  logic [31:0]                       mem_wb_alu_result;
  logic [31:0]                       mem_wb_mem_data;
  logic [31:0]                       ex_mem_alu_result_fwd;
  logic                              branch_taken;
  logic [31:0]                       branch_target;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_reg = 32'd0;
  logic [31:0] exp_alu;
  logic        exp_taken;
  logic [31:0] exp_target;

  ex_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .id_ex_pc              (id_ex_pc),
    .id_ex_instruction     (id_ex_instruction),
    .id_ex_rs1_data        (id_ex_rs1_data),
    .id_ex_rs2_data        (id_ex_rs2_data),
    .id_ex_immediate       (id_ex_immediate),
    .id_ex_rd_addr         (id_ex_rd_addr),
    .id_ex_rs1_addr        (id_ex_rs1_addr),
    .id_ex_rs2_addr        (id_ex_rs2_addr),
    .id_ex_control_signals (id_ex_control_signals),
    .id_ex_valid           (id_ex_valid),
    .forward_a             (forward_a),
    .forward_b             (forward_b),
    .mem_wb_alu_result     (mem_wb_alu_result),
    .mem_wb_mem_data       (mem_wb_mem_data),
    .ex_mem_alu_result_fwd (ex_mem_alu_result_fwd),
    .branch_taken          (branch_taken),
    .branch_target         (branch_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    case (sel)
      2'd0:    return rf;
      2'd1:    return mem_wb_alu_result;
      2'd2:    return exp_reg;
      default: return mem_wb_mem_data;
    endcase
  endfunction

  // Reference ALU result from the RV32I/RV32M instruction definitions.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] r2);
    logic [6:0]  opc = id_ex_instruction[6:0];
    logic [2:0]  f3  = id_ex_instruction[14:12];
    logic [6:0]  f7  = id_ex_instruction[31:25];
    logic [31:0] imm = id_ex_immediate;
    logic [31:0] b   = (opc == 7'b0110011) ? r2 : imm;
    int          sh  = int'(b % 32);
    longint      sa  = longint'(int'(a));
    longint      sb  = longint'(int'(b));
    longint      ua  = longint'({32'd0, a});
    longint unsigned uua = {32'd0, a};
    longint unsigned uub = {32'd0, b};
    logic [63:0] p;
    if (opc == 7'b0110011 && f7 == 7'b0000001) begin
`ifdef EX_MUL_EN
      case (f3)
        3'd0: begin p = sa * sb; return p[31:0]; end
        3'd1: begin p = sa * sb; return p[63:32]; end
        3'd2: begin p = sa * longint'(uub); return p[63:32]; end
        3'd3: begin p = uua * uub; return p[63:32]; end
        default: return 32'd0;
      endcase
`else
      return 32'd0;
`endif
    end
    if (ua < 0) return 32'hdead_beef;
    case (opc)
      7'b0110011, 7'b0010011: begin
        case (f3)
          3'd0: return (opc == 7'b0110011 && f7[5]) ? a - b : a + b;
          3'd1: return a << sh;
          3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          3'd3: return (ua < longint'({32'd0, b})) ? 32'd1 : 32'd0;
          3'd4: return a ^ b;
          3'd5: return f7[5] ? 32'(int'(a) >>> sh) : a >> sh;
          3'd6: return a | b;
          default: return a & b;
        endcase
      end
      7'b0000011, 7'b0100011: return a + imm;
      7'b0110111:             return imm;
      7'b0010111:             return id_ex_pc + imm;
      7'b1101111, 7'b1100111: return id_ex_pc + 32'd4;
      default:                return 32'd0;
    endcase
  endfunction

  // Reference branch/jump decision and redirect address.
  task automatic ref_branch(input logic [31:0] a, input logic [31:0] b);
    logic [6:0] opc = id_ex_instruction[6:0];
    logic       cond;
    case (id_ex_instruction[14:12])
      3'd0:    cond = (a == b);
      3'd1:    cond = (a != b);
      3'd4:    cond = int'(a) < int'(b);
      3'd5:    cond = int'(a) >= int'(b);
      3'd6:    cond = longint'({32'd0, a}) <  longint'({32'd0, b});
      3'd7:    cond = longint'({32'd0, a}) >= longint'({32'd0, b});
      default: cond = 1'b0;
    endcase
    exp_taken = !reset && id_ex_valid &&
                ((cond && id_ex_control_signals[`CTRL_BRANCH]) ||
                 opc == 7'b1101111 || opc == 7'b1100111);
    if (opc == 7'b1100111) exp_target = (a + id_ex_immediate) & 32'hffff_fffe;
    else                   exp_target = id_ex_pc + id_ex_immediate;
  endtask

  // Let inputs settle, then compare the combinational outputs with the model.
  task automatic settle(input string tag);
    logic [31:0] a;
    logic [31:0] b;
    #1;
    a = pick(forward_a, id_ex_rs1_data);
    b = pick(forward_b, id_ex_rs2_data);
    ref_branch(a, b);
    exp_alu = ref_alu(a, b);
    chk({tag, "_taken"}, {31'd0, branch_taken}, {31'd0, exp_taken});
    if (exp_taken) chk({tag, "_target"}, branch_target, exp_target);
  endtask

  // Clock one edge and compare the EX/MEM register with the model.
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset)            exp_reg = 32'd0;
    else if (id_ex_valid) exp_reg = exp_alu;
    #1;
    chk({tag, "_reg"}, ex_mem_alu_result_fwd, exp_reg);
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    id_ex_instruction = {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endtask

  task automatic set_br(input logic b);
    id_ex_control_signals = '0;
    id_ex_control_signals[`CTRL_BRANCH] = b;
  endtask

  task automatic branch_case(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic exp);
    set_instr(7'b1100011, f3, 7'd0);
    id_ex_rs1_data = a;
    id_ex_rs2_data = b;
    settle("dir_br");
    chk("dir_br_literal", {31'd0, branch_taken}, {31'd0, exp});
    tick("dir_br");
  endtask

  logic [6:0] opcs [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
                            7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b1111111};

  initial begin
    logic [6:0] f7r;
    reset = 1'b1;
    id_ex_pc = '0; id_ex_instruction = '0; id_ex_rs1_data = '0; id_ex_rs2_data = '0;
    id_ex_immediate = '0; id_ex_rd_addr = '0; id_ex_rs1_addr = '0; id_ex_rs2_addr = '0;
    id_ex_control_signals = '0; id_ex_valid = 1'b1; forward_a = '0; forward_b = '0;
    mem_wb_alu_result = '0; mem_wb_mem_data = '0;

    // Reset state.
    settle("rst");
    tick("rst");
    chk("rst_reg_zero", ex_mem_alu_result_fwd, 32'd0);
    reset = 1'b0;

    // Conditional branches, pc=0x1000, imm=4.
    id_ex_pc = 32'h1000; id_ex_immediate = 32'd4; set_br(1'b1);
    set_instr(7'b1100011, 3'd0, 7'd0); id_ex_rs1_data = 32'd10; id_ex_rs2_data = 32'd10;
    settle("beq_tgt");
    chk("beq_target", branch_target, 32'h1004);
    tick("beq_tgt");
    branch_case(3'd0, 32'd10, 32'd10, 1'b1);
    branch_case(3'd0, 32'd10, 32'd11, 1'b0);
    branch_case(3'd1, 32'd10, 32'd11, 1'b1);
    branch_case(3'd1, 32'd12, 32'd12, 1'b0);
    branch_case(3'd4, -32'sd5, 32'd2, 1'b1);
    branch_case(3'd4, 32'd4, -32'sd1, 1'b0);
    branch_case(3'd5, 32'd5, 32'd5, 1'b1);
    branch_case(3'd5, 32'd7, -32'sd1, 1'b1);
    branch_case(3'd6, 32'd3, 32'd9, 1'b1);
    branch_case(3'd6, 32'd9, 32'd3, 1'b0);
    branch_case(3'd7, 32'd6, 32'd6, 1'b1);
    branch_case(3'd7, 32'd8, 32'd2, 1'b1);
    branch_case(3'd2, 32'd1, 32'd9, 1'b0);

    // Reset and bubble suppress a taken branch.
    reset = 1'b1;
    branch_case(3'd0, 32'd10, 32'd10, 1'b0);
    reset = 1'b0;
    id_ex_valid = 1'b0;
    branch_case(3'd0, 32'd10, 32'd10, 1'b0);
    id_ex_valid = 1'b1;

    // ADD then SUB forwarding from the EX/MEM register.
    set_br(1'b0);
    set_instr(7'b0110011, 3'd0, 7'd0); id_ex_rs1_data = 32'd7; id_ex_rs2_data = 32'd5;
    settle("add"); tick("add");
    chk("add_literal", ex_mem_alu_result_fwd, 32'd12);
    set_instr(7'b0110011, 3'd0, 7'b0100000); forward_a = 2'b10; id_ex_rs2_data = 32'd2;
    settle("sub"); tick("sub");
    chk("sub_fwd_literal", ex_mem_alu_result_fwd, 32'd10);
    forward_a = 2'b00;

    // Bubble holds the register.
    id_ex_valid = 1'b0; id_ex_rs1_data = 32'd99;
    settle("bubble"); tick("bubble");
    chk("bubble_hold", ex_mem_alu_result_fwd, 32'd10);
    id_ex_valid = 1'b1;

    // JALR.
    set_instr(7'b1100111, 3'd0, 7'd0); id_ex_rs1_data = 32'h2003;
    id_ex_immediate = 32'd4; id_ex_pc = 32'h100;
    settle("jalr");
    chk("jalr_taken", {31'd0, branch_taken}, 32'd1);
    chk("jalr_target", branch_target, 32'h2006);
    tick("jalr");
    chk("jalr_link", ex_mem_alu_result_fwd, 32'h104);

    // Multiply subset.
    set_instr(7'b0110011, 3'd0, 7'b0000001); id_ex_rs1_data = 32'd6; id_ex_rs2_data = 32'd7;
    settle("mul"); tick("mul");
`ifdef EX_MUL_EN
    chk("mul_literal", ex_mem_alu_result_fwd, 32'd42);
`else
    chk("mul_off_literal", ex_mem_alu_result_fwd, 32'd0);
`endif
    set_instr(7'b0110011, 3'd3, 7'b0000001);
    id_ex_rs1_data = 32'hffff_ffff; id_ex_rs2_data = 32'd2;
    settle("mulhu"); tick("mulhu");
`ifdef EX_MUL_EN
    chk("mulhu_literal", ex_mem_alu_result_fwd, 32'd1);
`else
    chk("mulhu_off_literal", ex_mem_alu_result_fwd, 32'd0);
`endif

    // Randomized vectors against the reference model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       f7r = 7'b0100000;
        1:       f7r = 7'b0000001;
        default: f7r = 7'b0000000;
      endcase
      id_ex_instruction     = {f7r, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
                               opcs[$urandom_range(0, 9)]};
      id_ex_pc              = $urandom;
      id_ex_rs1_data        = ($urandom_range(0, 3) == 0) ? id_ex_rs2_data : $urandom;
      id_ex_rs2_data        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      id_ex_immediate       = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      id_ex_rd_addr         = 5'($urandom);
      id_ex_rs1_addr        = 5'($urandom);
      id_ex_rs2_addr        = 5'($urandom);
      id_ex_control_signals = `CONTROL_SIGNALS_WIDTH'($urandom);
      id_ex_valid           = ($urandom_range(0, 3) != 0);
      reset                 = ($urandom_range(0, 15) == 0);
      forward_a             = 2'($urandom);
      forward_b             = 2'($urandom);
      mem_wb_alu_result     = $urandom;
      mem_wb_mem_data       = $urandom;
      settle("rnd");
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
